// File: rtl/boot_loader_if.sv
// Byte-stream and RAM write-port bundle for the boot loader.
// master drives the byte stream; slave is the loader itself.
interface boot_loader_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_rst_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output rx_data_i, rx_valid_i,
    input  rx_ready_o, mem_we_o, mem_addr_o,
    input  mem_data_o, cpu_rst_o, done_o, err_o
  );

  modport slave (
    input  rx_data_i, rx_valid_i,
    output rx_ready_o, mem_we_o, mem_addr_o,
    output mem_data_o, cpu_rst_o, done_o, err_o
  );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: receives count/words/checksum over a byte stream,
// writes words to RAM and releases the core on a good checksum.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  boot_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    LEN0, LEN1, DATA, CSUM, RUN, ERR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [15:0] wcnt_q;
  logic [1:0]  bidx_q;
  logic [23:0] part_q;
  logic [7:0]  csum_q;
  logic        rdy_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic        acc;
  logic [15:0] cnt_full;
  logic [15:0] wcnt_inc;
  logic        last_word;
  logic [7:0]  rx;

  assign rx        = bus.rx_data_i;
  assign acc       = bus.rx_valid_i & rdy_q;
  assign cnt_full  = {rx, cnt_q[7:0]};
  assign wcnt_inc  = wcnt_q + 16'd1;
  assign last_word = (wcnt_inc == cnt_q);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= LEN0;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEN0: if (acc) state_d = LEN1;
      LEN1: begin
        if (acc) begin
          if ({1'b0, cnt_full} > MAX_W)
            state_d = ERR;
          else if (cnt_full == 16'd0)
            state_d = CSUM;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (acc && bidx_q == 2'd3 && last_word)
          state_d = CSUM;
      end
      CSUM: begin
        if (acc)
          state_d = (rx == csum_q) ? RUN : ERR;
      end
      default: state_d = state_q;
    endcase
  end

  // Count, word assembly, checksum and write port
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      wcnt_q <= '0;
      bidx_q <= '0;
      part_q <= '0;
      csum_q <= '0;
      rdy_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      rdy_q <= state_d inside {LEN0, LEN1, DATA, CSUM};
      we_q  <= 1'b0;
      if (acc) begin
        unique case (state_q)
          LEN0: begin
            cnt_q[7:0] <= rx;
            csum_q     <= csum_q + rx;
          end
          LEN1: begin
            cnt_q[15:8] <= rx;
            csum_q      <= csum_q + rx;
          end
          DATA: begin
            csum_q <= csum_q + rx;
            bidx_q <= bidx_q + 2'd1;
            unique case (bidx_q)
              2'd0: part_q[7:0]   <= rx;
              2'd1: part_q[15:8]  <= rx;
              2'd2: part_q[23:16] <= rx;
              2'd3: begin
                we_q   <= 1'b1;
                addr_q <= BASE_ADDR + {14'd0, wcnt_q, 2'b00};
                data_q <= {rx, part_q};
                wcnt_q <= wcnt_inc;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready_o = rdy_q;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign bus.cpu_rst_o  = (state_q != RUN);
  assign bus.done_o     = (state_q == RUN);
  assign bus.err_o      = (state_q == ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader (MAX_WORDS=4, BASE_ADDR=0).
// Writes are captured on the falling edge and compared to tables.
module tb_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;

  boot_loader_if bus ();

  boot_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  stream[$];
  logic [31:0] wa[$], wd[$];
  logic [31:0] ea[$], ed[$];

  // Capture every write strobe
  always @(negedge clk) begin
    if (bus.mem_we_o) begin
      wa.push_back(bus.mem_addr_o);
      wd.push_back(bus.mem_data_o);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 8'hA5;
    wa.delete();
    wd.delete();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.rx_ready_o), 0);
    check("rst_we",    32'(bus.mem_we_o),   0);
    check("rst_addr",  bus.mem_addr_o,      0);
    check("rst_data",  bus.mem_data_o,      0);
    check("rst_cpu",   32'(bus.cpu_rst_o),  1);
    check("rst_done",  32'(bus.done_o),     0);
    check("rst_err",   32'(bus.err_o),      0);
    check("rst_nowr",  32'(wa.size()),      0);
    rst = 1'b1;
    bus.rx_valid_i = 1'b0;
  endtask

  // Entered and left on a falling edge
  task automatic send(input bit gap);
    for (int i = 0; i < stream.size(); i++) begin
      int n = 0;
      bus.rx_data_i  = stream[i];
      bus.rx_valid_i = 1'b1;
      while (!bus.rx_ready_o && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        check("ready_timeout", 0, 1);
        bus.rx_valid_i = 1'b0;
        return;
      end
      @(negedge clk);
      if (gap) begin
        bus.rx_valid_i = 1'b0;
        @(negedge clk);
      end
    end
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic chk_writes();
    check("n_writes", 32'(wa.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      check("wr_addr", wa[i], ea[i]);
      check("wr_data", wd[i], ed[i]);
    end
  endtask

  task automatic chk_end(input logic done, input logic err);
    check("end_done",  32'(bus.done_o),     32'(done));
    check("end_err",   32'(bus.err_o),      32'(err));
    check("end_cpu",   32'(bus.cpu_rst_o),  32'(!done));
    check("end_ready", 32'(bus.rx_ready_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    repeat (2) @(negedge clk);

    // Nominal load, release timing
    do_reset();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
               8'h00, 8'h93, 8'h00, 8'hA0, 8'h02};
    send(1'b0);
    check("pre_done", 32'(bus.done_o),    0);
    check("pre_cpu",  32'(bus.cpu_rst_o), 1);
    stream = '{8'h4A};
    send(1'b0);
    chk_end(1'b1, 1'b0);
    ea = '{32'h0, 32'h4};
    ed = '{32'h0000_0013, 32'h02A0_0093};
    chk_writes();

    // Valid held in RUN is ignored
    bus.rx_data_i  = 8'h13;
    bus.rx_valid_i = 1'b1;
    repeat (6) @(negedge clk);
    bus.rx_valid_i = 1'b0;
    check("run_nowr", 32'(wa.size()), 2);
    chk_end(1'b1, 1'b0);

    // Bad checksum
    do_reset();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'hA0, 8'h02, 8'h4B};
    send(1'b0);
    @(negedge clk);
    chk_end(1'b0, 1'b1);
    chk_writes();

    // Oversize count
    do_reset();
    stream = '{8'h05, 8'h00};
    send(1'b0);
    chk_end(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("over_nowr", 32'(wa.size()), 0);

    // Count exactly MAX_WORDS is accepted
    do_reset();
    stream = '{8'h04, 8'h00};
    for (int i = 1; i <= 16; i++) stream.push_back(8'(i));
    stream.push_back(8'h8C);
    send(1'b0);
    @(negedge clk);
    chk_end(1'b1, 1'b0);
    ea = '{32'h0, 32'h4, 32'h8, 32'hC};
    ed = '{32'h0403_0201, 32'h0807_0605,
           32'h0C0B_0A09, 32'h100F_0E0D};
    chk_writes();

    // Zero count
    do_reset();
    stream = '{8'h00, 8'h00, 8'h00};
    send(1'b0);
    chk_end(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("zero_nowr", 32'(wa.size()), 0);

    // All-ones word, checksum wraps
    do_reset();
    stream = '{8'h01, 8'h00, 8'hFF, 8'hFF,
               8'hFF, 8'hFF, 8'hFD};
    send(1'b0);
    @(negedge clk);
    chk_end(1'b1, 1'b0);
    ea = '{32'h0};
    ed = '{32'hFFFF_FFFF};
    chk_writes();

    // Gapped nominal stream
    do_reset();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'hA0, 8'h02, 8'h4A};
    send(1'b1);
    chk_end(1'b1, 1'b0);
    ea = '{32'h0, 32'h4};
    ed = '{32'h0000_0013, 32'h02A0_0093};
    chk_writes();

    // Reset after five bytes, then full reload
    do_reset();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
    send(1'b0);
    check("mid_nowr", 32'(wa.size()), 0);
    do_reset();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'hA0, 8'h02, 8'h4A};
    send(1'b0);
    chk_end(1'b1, 1'b0);
    chk_writes();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
